present_iter_core: RTL and testbench
====================================

# present_iter_core

Parametrised iterative PRESENT block-cipher core. Supports 80- or 128-bit keys, a configurable round count, and valid/ready handshakes on both input and output. Optionally supports decryption. It is the next generation of the team's fixed-configuration PRESENT-128 encryptor and is intended to sit behind a stream/DMA wrapper in the crypto datapath. One round is computed per clock.

## Interface
- `KEY_WIDTH`, default 128: key size; legal values are 80 and 128. Any other value is an elaboration error.
- `ROUNDS`, default 31: number of full rounds, legal range 1..31. The round counter is 5 bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low (`clk`, `rst_n`).
- `in_valid`  in  1  the input block, key and mode are valid.
- `in_ready`  out  1  core is idle and can accept a block.
- `in_data`  in  64  plaintext, or ciphertext when decrypting.
- `in_key`  in  KEY_WIDTH  cipher key, master key form in both modes.
- `in_decrypt`  in  1  1 = decrypt. Only present with `PRESENT_ITER_DECRYPT_EN`.
- `out_valid`  out  1  result valid; held until it is accepted.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  64  result block.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, KEYGEN, RUN, DONE. KEYGEN exists only when decrypt is compiled in.
- **Round function (encrypt, counter r = 1..ROUNDS):**
  - s ^= K_r, where K_r is the top 64 bits of the key register.
  - Apply S-box C56B90AD3EF84712 to all 16 nibbles.
  - Apply pLayer: bit i moves to bit (16·i) mod 63; bit 63 stays in place.
- **Key update (encrypt), after each round:**
  - Rotate the key register left by 61.
  - 80-bit key: S-box the top nibble [79:76], then XOR r into bits [19:15].
  - 128-bit key: S-box the top two nibbles [127:120], then XOR r into bits [66:62].
- **Final whitening:** out_data = state ^ K_(ROUNDS+1).
- **Accept:** an accept occurs on an edge where in_valid && in_ready.
  - The core latches the data and key and sets r = 1.
  - For encrypt, the next state is RUN.
  - For decrypt, the next state is KEYGEN.
- **KEYGEN (decrypt only):**
  - Runs ROUNDS cycles of the encrypt key update only; the data register is untouched.
  - At the end the key register holds K_(ROUNDS+1).
  - r is left at ROUNDS, and the core enters RUN.
- **RUN, encrypt:** one round per cycle with r incrementing.
  - On the edge with r == ROUNDS, out_data is registered as pLayer(S(s ^ K_r)) ^ K_(r+1).
  - The core then enters DONE.
- **RUN, decrypt:** the inverse round is applied with r counting down from ROUNDS to 1.
  - Data: s ^= K_(r+1), then inverse pLayer, then inverse S-box (5EF8C12DB463079A).
  - Key: undo the r XOR, apply the inverse S-box to the top nibble(s), then rotate right by 61.
  - On the edge with r == 1, out_data is registered as the result ^ K_1.
- **DONE:**
  - out_valid = 1 and out_data is held stable.
  - When out_valid && out_ready, the core moves to IDLE.
- **Handshake outputs:**
  - in_ready = (state == IDLE). There is no input acceptance in DONE, so there is no simultaneous in/out transfer.
  - in_data, in_key and in_decrypt are ignored when not accepted. Changes to them during RUN have no effect.
- **Reset:**
  - Reset is sampled on every edge. rst_n low mid-operation aborts the computation.
  - On reset the core returns to IDLE, and the counter and registers clear.
  - Any pending result is discarded.

## Timing
- **Values on the edge where rst_n is low, and after it:**
  - out_valid = 0, out_data = 0, busy = 0, in_ready = 1, r = 0.
  - The data and key registers are 0.
- **Encrypt latency:** the accept edge is T; out_valid rises after edge T+ROUNDS.
- **Decrypt latency:** out_valid rises after edge T+2·ROUNDS.
- **Throughput (encrypt):**
  - With out_ready tied high, one block per ROUNDS+2 cycles.
  - The cycle structure is accept, ROUNDS round cycles, then one DONE cycle; in_ready returns the cycle after the output handshake.
- **Backpressure:** out_ready low holds DONE indefinitely. out_data must not change during this time.
- **No combinational paths** from in_valid or out_ready to any output other than through the state register.

## Configuration
- `PRESENT_ITER_DECRYPT_EN` defined:
  - The in_decrypt port, the KEYGEN state, the inverse S-box, the inverse pLayer and the inverse key schedule are compiled in.
- Not defined:
  - The in_decrypt port is absent and the core is encrypt-only.
  - KEYGEN and all inverse logic are removed.
  - Encrypt behaviour and latency are identical in both builds.

## Test plan
- **PRESENT-80 encrypt vectors:** KEY_WIDTH=80, ROUNDS=31, out_ready=1.
  - pt 0, key 0 gives 5579C1387B228445.
  - pt 0, key FFFF…F gives E72C46C0F5945049.
  - pt FFFF…F, key FFFF…F gives 3333DCD3213210D2.
  - out_valid must rise exactly 31 edges after the accept edge.
- **PRESENT-128 encrypt:** pt 0, key 0 gives 96DB702A2E6900AF.
  - in_ready = 0 and busy = 1 must hold throughout the run.
- **Decrypt round-trip:** with the macro on, decrypt 5579C1387B228445 using key 0 (80-bit) and in_decrypt=1.
  - Result must be 0000000000000000, with out_valid rising 62 edges after accept.
  - Repeat with 32 random pt/key pairs in both key widths.
- **Backpressure:** hold out_ready=0 for 10 cycles in DONE.
  - out_valid and out_data must stay stable, and in_valid=1 must not be accepted.
  - After out_ready=1, in_ready=1 on the next cycle.
- **Reset mid-run:** drop rst_n for 1 cycle at round 12.
  - Next cycle: out_valid=0, in_ready=1, busy=0.
  - A subsequent pt 0 / key 0 (80-bit) run must produce the correct 5579C1387B228445.
- **Short round count:** ROUNDS=1, KEY_WIDTH=80, pt 0, key 0.
  - out_data must be pLayer(S(0)) ^ K_2, matching the reference model.
  - out_valid must rise 1 edge after accept.

Source files
------------

// File: rtl/present_iter_core.sv
// present_iter_core: iterative PRESENT-80/128 block cipher, one round per clock, valid/ready on both sides.
// Define PRESENT_ITER_DECRYPT_EN to add the in_decrypt port, the KEYGEN state and the inverse datapath.
module present_iter_core #(
  parameter int KEY_WIDTH = 128,
  parameter int ROUNDS    = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_data,
  input  logic [KEY_WIDTH-1:0] in_key,
`ifdef PRESENT_ITER_DECRYPT_EN
  input  logic                 in_decrypt,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic                 busy
);

  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_iter_core: ROUNDS must be in 1..31");
  end

  localparam logic [63:0] SBOX     = 64'hC56B90AD3EF84712;
  localparam logic [63:0] INV_SBOX = 64'h5EF8C12DB463079A;
  localparam logic [4:0]  LAST     = 5'(ROUNDS);

`ifdef PRESENT_ITER_DECRYPT_EN
  typedef enum logic [1:0] {IDLE, KEYGEN, RUN, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t               state_q;
  logic [63:0]          data_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [4:0]           rnd_q;
  logic [KEY_WIDTH-1:0] key_fwd;
  logic [63:0]          rk_cur;
  logic [63:0]          rk_fwd;
  logic [63:0]          enc_round;

  // Table nibble 0 sits in the top bits, so the bit offset is (15 - x) * 4 = {~x, 2'b00}.
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[{~x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned n = 0; n < 16; n++) y[4*n +: 4] = sbox4(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    y[63] = x[63];
    for (int unsigned i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
    return y;
  endfunction

`ifdef PRESENT_ITER_DECRYPT_EN
  logic                 dec_q;
  logic [KEY_WIDTH-1:0] key_inv;
  logic [63:0]          rk_inv;
  logic [63:0]          dec_round;

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    return INV_SBOX[{~x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned n = 0; n < 16; n++) y[4*n +: 4] = inv_sbox4(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    y[63] = x[63];
    for (int unsigned i = 0; i < 63; i++) y[i] = x[(16*i) % 63];
    return y;
  endfunction
`endif

  if (KEY_WIDTH == 80) begin : g_ks
    always_comb begin
      key_fwd        = {key_q[18:0], key_q[79:19]};
      key_fwd[79:76] = sbox4(key_fwd[79:76]);
      key_fwd[19:15] = key_fwd[19:15] ^ rnd_q;
    end
`ifdef PRESENT_ITER_DECRYPT_EN
    logic [79:0] key_t;
    always_comb begin
      key_t        = key_q;
      key_t[19:15] = key_q[19:15] ^ rnd_q;
      key_t[79:76] = inv_sbox4(key_q[79:76]);
      key_inv      = {key_t[60:0], key_t[79:61]};
    end
`endif
  end else if (KEY_WIDTH == 128) begin : g_ks
    always_comb begin
      key_fwd          = {key_q[66:0], key_q[127:67]};
      key_fwd[127:124] = sbox4(key_fwd[127:124]);
      key_fwd[123:120] = sbox4(key_fwd[123:120]);
      key_fwd[66:62]   = key_fwd[66:62] ^ rnd_q;
    end
`ifdef PRESENT_ITER_DECRYPT_EN
    logic [127:0] key_t;
    always_comb begin
      key_t          = key_q;
      key_t[66:62]   = key_q[66:62] ^ rnd_q;
      key_t[127:124] = inv_sbox4(key_q[127:124]);
      key_t[123:120] = inv_sbox4(key_q[123:120]);
      key_inv        = {key_t[60:0], key_t[127:61]};
    end
`endif
  end else begin : g_ks
    $error("present_iter_core: KEY_WIDTH must be 80 or 128");
    always_comb begin
      key_fwd = '0;
`ifdef PRESENT_ITER_DECRYPT_EN
      key_inv = '0;
`endif
    end
  end

  assign rk_cur    = key_q[KEY_WIDTH-1 -: 64];
  assign rk_fwd    = key_fwd[KEY_WIDTH-1 -: 64];
  assign enc_round = p_layer(s_layer(data_q ^ rk_cur));
`ifdef PRESENT_ITER_DECRYPT_EN
  assign rk_inv    = key_inv[KEY_WIDTH-1 -: 64];
  assign dec_round = inv_s_layer(inv_p_layer(data_q ^ rk_cur));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      key_q     <= '0;
      rnd_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
`ifdef PRESENT_ITER_DECRYPT_EN
      dec_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            key_q    <= in_key;
            rnd_q    <= 5'd1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef PRESENT_ITER_DECRYPT_EN
            dec_q    <= in_decrypt;
            state_q  <= in_decrypt ? KEYGEN : RUN;
`else
            state_q  <= RUN;
`endif
          end
        end
`ifdef PRESENT_ITER_DECRYPT_EN
        // Walk the encrypt schedule forward so RUN can peel round keys off in reverse.
        KEYGEN: begin
          key_q <= key_fwd;
          if (rnd_q == LAST) state_q <= RUN;
          else               rnd_q   <= rnd_q + 5'd1;
        end
`endif
        RUN: begin
`ifdef PRESENT_ITER_DECRYPT_EN
          if (dec_q) begin
            data_q <= dec_round;
            key_q  <= key_inv;
            if (rnd_q == 5'd1) begin
              out_data  <= dec_round ^ rk_inv;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end else begin
              rnd_q <= rnd_q - 5'd1;
            end
          end else
`endif
          begin
            data_q <= enc_round;
            key_q  <= key_fwd;
            if (rnd_q == LAST) begin
              out_data  <= enc_round ^ rk_fwd;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end else begin
              rnd_q <= rnd_q + 5'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_iter_core.sv
// Scoreboarded bench for present_iter_core: PRESENT-80/31, PRESENT-128/31 and PRESENT-80/1 instances
// checked against a key-schedule/round model built from plain shifts and a lookup table.
module tb_present_iter_core;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid  [N];
  logic         in_ready  [N];
  logic [63:0]  in_data   [N];
  logic [127:0] in_key    [N];
  logic         out_valid [N];
  logic         out_ready [N];
  logic [63:0]  out_data  [N];
  logic         busy      [N];
`ifdef PRESENT_ITER_DECRYPT_EN
  logic         in_decrypt [N];
`endif

  logic [63:0] exp_q [N][$];
  int checks = 0;
  int errors = 0;

  int unsigned sb_tab [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  present_iter_core #(.KEY_WIDTH(80), .ROUNDS(31)) u_p80 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_key(in_key[0][79:0]),
`ifdef PRESENT_ITER_DECRYPT_EN
    .in_decrypt(in_decrypt[0]),
`endif
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
  );

  present_iter_core #(.KEY_WIDTH(128), .ROUNDS(31)) u_p128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_key(in_key[1]),
`ifdef PRESENT_ITER_DECRYPT_EN
    .in_decrypt(in_decrypt[1]),
`endif
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );

  present_iter_core #(.KEY_WIDTH(80), .ROUNDS(1)) u_p80_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_key(in_key[2][79:0]),
`ifdef PRESENT_ITER_DECRYPT_EN
    .in_decrypt(in_decrypt[2]),
`endif
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
  );

  function automatic int kw_of(input int i);
    return (i == 1) ? 128 : 80;
  endfunction

  function automatic int nr_of(input int i);
    return (i == 2) ? 1 : 31;
  endfunction

  // Reference encryption: key held right-aligned in a 128-bit word, round key = its top 64 bits.
  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [127:0] key,
                                          input int kw, input int nr);
    logic [127:0] mask, k;
    logic [63:0]  s, t;
    int unsigned  nib;
    mask = (128'd1 << kw) - 128'd1;
    k = key & mask;
    s = pt;
    for (int r = 1; r <= nr; r++) begin
      s = s ^ 64'(k >> (kw - 64));
      for (int n = 0; n < 16; n++) begin
        nib = 32'((s >> (4 * n)) & 64'hF);
        t[4*n +: 4] = 4'(sb_tab[nib]);
      end
      for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16 * i) % 63] = t[i];
      k = ((k << 61) | (k >> (kw - 61))) & mask;
      for (int j = 1; j <= ((kw == 80) ? 1 : 2); j++) begin
        nib = 32'((k >> (kw - 4 * j)) & 128'hF);
        k = (k & ~(128'hF << (kw - 4 * j))) | (128'(sb_tab[nib]) << (kw - 4 * j));
      end
      k = k ^ (128'(r) << ((kw == 80) ? 15 : 62));
    end
    return s ^ 64'(k >> (kw - 64));
  endfunction

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Output monitor: a result is consumed on the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output[%0d]: got %0h expected no output", i, out_data[i]);
          end else begin
            check($sformatf("out_data[%0d]", i), out_data[i], exp_q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic send(input int i, input logic [63:0] d, input logic [127:0] k, input logic dec,
                      input logic [63:0] exp, output int lat, output logic held);
    int n;
    n = 0;
    while (!in_ready[i] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("in_ready_before_send[%0d]", i), in_ready[i], 1);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_key[i]   = k;
`ifdef PRESENT_ITER_DECRYPT_EN
    in_decrypt[i] = dec;
`endif
    exp_q[i].push_back(exp);
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    in_data[i]  = {$urandom, $urandom};
    in_key[i]   = {$urandom, $urandom, $urandom, $urandom};
`ifdef PRESENT_ITER_DECRYPT_EN
    in_decrypt[i] = ~dec;
`endif
    lat  = 0;
    held = 1'b1;
    while (!out_valid[i] && lat < 200) begin
      if (in_ready[i] || !busy[i]) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int           lat;
  logic         held;
  logic         stable;
  logic [63:0]  pt, snap;
  logic [127:0] key;

  initial begin
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      in_data[i]   = '0;
      in_key[i]    = '0;
`ifdef PRESENT_ITER_DECRYPT_EN
      in_decrypt[i] = 1'b0;
`endif
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_out_valid[%0d]", i), out_valid[i], 0);
      check($sformatf("reset_out_data[%0d]", i), out_data[i], 0);
      check($sformatf("reset_busy[%0d]", i), busy[i], 0);
      check($sformatf("reset_in_ready[%0d]", i), in_ready[i], 1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer vectors
    send(0, 64'h0, 128'h0, 1'b0, 64'h5579C1387B228445, lat, held);
    check("p80_latency", lat, 31);
    send(0, 64'h0, '1, 1'b0, 64'hE72C46C0F5945049, lat, held);
    send(0, '1, '1, 1'b0, 64'h3333DCD3213210D2, lat, held);
    send(1, 64'h0, 128'h0, 1'b0, 64'h96DB702A2E6900AF, lat, held);
    check("p128_latency", lat, 31);
    check("p128_busy_not_ready_during_run", held, 1);
    send(2, 64'h0, 128'h0, 1'b0, ref_enc(64'h0, 128'h0, 80, 1), lat, held);
    check("r1_latency", lat, 1);

    // Random encryption against the model
    for (int t = 0; t < 24; t++) begin
      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      send(t % N, pt, key, 1'b0, ref_enc(pt, key, kw_of(t % N), nr_of(t % N)), lat, held);
    end

    // Backpressure in DONE
    out_ready[0] = 1'b0;
    pt  = {$urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    send(0, pt, key, 1'b0, ref_enc(pt, key, 80, 31), lat, held);
    snap   = out_data[0];
    stable = 1'b1;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!out_valid[0] || out_data[0] !== snap || in_ready[0] || !busy[0]) stable = 1'b0;
    end
    check("bp_held_stable", stable, 1);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", in_ready[0], 1);
    check("bp_out_valid_after", out_valid[0], 0);
    check("bp_busy_after", busy[0], 0);

    // Reset at round 12; the aborted block must never emerge
    in_valid[0] = 1'b1;
    in_data[0]  = {$urandom, $urandom};
    in_key[0]   = {$urandom, $urandom, $urandom, $urandom};
`ifdef PRESENT_ITER_DECRYPT_EN
    in_decrypt[0] = 1'b0;
`endif
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_out_valid", out_valid[0], 0);
    check("rst_mid_in_ready", in_ready[0], 1);
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_out_data", out_data[0], 0);
    send(0, 64'h0, 128'h0, 1'b0, 64'h5579C1387B228445, lat, held);
    check("rst_rerun_latency", lat, 31);

`ifdef PRESENT_ITER_DECRYPT_EN
    // Decryption round trips
    send(0, 64'h5579C1387B228445, 128'h0, 1'b1, 64'h0, lat, held);
    check("dec80_latency", lat, 62);
    send(1, 64'h96DB702A2E6900AF, 128'h0, 1'b1, 64'h0, lat, held);
    check("dec128_latency", lat, 62);
    for (int t = 0; t < 64; t++) begin
      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      send(t % 2, ref_enc(pt, key, kw_of(t % 2), 31), key, 1'b1, pt, lat, held);
    end
    for (int t = 0; t < 4; t++) begin
      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      send(2, ref_enc(pt, key, 80, 1), key, 1'b1, pt, lat, held);
      check("dec_r1_latency", lat, 2);
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) check($sformatf("scoreboard_drained[%0d]", i), exp_q[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected the run to end before the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
